// File: rtl/exp2_seq.sv
// exp2_seq: sequential 2^x unit for Q4.7 log inputs, producing a Q16.8 result.
// The fraction part is rebuilt in a Q1.16 accumulator by multiplying in one
// constant per set fraction bit (MSB first, one bit per cycle). The integer
// part is then applied as a left shift.
module exp2_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_log,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_y,
  output logic        out_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // 1.0 in Q1.16
  localparam logic [16:0] ACC_ONE = 17'd65536;

  logic [1:0]  state_q, state_d;
  logic [16:0] acc_q, acc_d;
  logic [2:0]  k_q, k_d;
  logic [3:0]  i_q, i_d;
  logic [6:0]  f_q, f_d;
  logic        z_q, z_d;
  logic [23:0] y_q, y_d;
  logic        oz_q, oz_d;
  logic [16:0] coef;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_y     = y_q;
  assign out_zero  = oz_q;

  // Per-step constant round(2^(2^-(k+1)) * 65536)
  always_comb begin
    coef = ACC_ONE;
    case (k_q)
      3'd0:    coef = 17'd92682;
      3'd1:    coef = 17'd77937;
      3'd2:    coef = 17'd71468;
      3'd3:    coef = 17'd68438;
      3'd4:    coef = 17'd66971;
      3'd5:    coef = 17'd66250;
      3'd6:    coef = 17'd65892;
      default: coef = ACC_ONE;
    endcase
  end

  // Next-state and datapath: accept, per-bit multiply, final shift, hold
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    i_d     = i_q;
    f_d     = f_q;
    z_d     = z_q;
    y_d     = y_q;
    oz_d    = oz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          i_d     = in_log[10:7];
          f_d     = in_log[6:0];
          z_d     = in_zero;
          acc_d   = ACC_ONE;
          k_d     = 3'd0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Truncating 17x17 multiply; the Q1.16 rescale is a plain >> 16
        if (f_q[3'd6 - k_q]) begin
          acc_d = 17'((34'(acc_q) * 34'(coef)) >> 16);
        end
        if (k_q == 3'd6) begin
          state_d = S_FINAL;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_FINAL: begin
        // Q1.16 shifted by I, then >> 8 lands in Q16.8; the low 24 bits always fit
        y_d     = z_q ? '0 : 24'((32'(acc_q) << i_q) >> 8);
        oz_d    = z_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_ONE;
      k_q     <= 3'd0;
      i_q     <= '0;
      f_q     <= '0;
      z_q     <= 1'b0;
      y_q     <= '0;
      oz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      i_q     <= i_d;
      f_q     <= f_d;
      z_q     <= z_d;
      y_q     <= y_d;
      oz_q    <= oz_d;
    end
  end

endmodule

// File: tb/tb_exp2_seq.sv
// Directed bench for exp2_seq: fixed vectors with hand-computed results,
// latency, backpressure, zero operand and mid-calculation reset.
module tb_exp2_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_log;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_y;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  exp2_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_log    (in_log),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one input for exactly one edge; returns #1 after the accept edge
  task automatic issue(input logic [10:0] lg, input logic zr);
    in_valid = 1'b1;
    in_log   = lg;
    in_zero  = zr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("accept_in_ready_low", {31'd0, in_ready}, 32'd0);
  endtask

  // Called #1 after accept edge n: out_valid low through n+7, high after n+8
  task automatic expect_result(input string tag, input logic [23:0] ey, input logic ez);
    repeat (7) @(posedge clk);
    #1;
    check({tag, "_valid_early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_y"}, {8'd0, out_y}, {8'd0, ey});
    check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, ez});
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("take_in_ready", {31'd0, in_ready}, 32'd1);
    check("take_valid_low", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_log    = '0;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_y", {8'd0, out_y}, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(11'h000, 1'b0);
    expect_result("one", 24'h000100, 1'b0);
    take();

    issue(11'(3 << 7), 1'b0);
    expect_result("int3", 24'd2048, 1'b0);
    take();

    issue(11'(15 << 7), 1'b0);
    expect_result("int15", 24'h800000, 1'b0);
    take();

    issue(11'h040, 1'b0);
    expect_result("f0p5", 24'd362, 1'b0);
    take();

    issue(11'h3C0, 1'b0);
    expect_result("f7p5", 24'h00B505, 1'b0);
    take();

    // Two fraction bits: floor(92682*77937/65536) = 110219, >> 8 = 430
    issue(11'h060, 1'b0);
    expect_result("f0p75", 24'd430, 1'b0);
    take();

    issue(11'h3C0, 1'b1);
    expect_result("zero_op", 24'd0, 1'b1);
    take();
    check("zero_held_idle", {31'd0, out_zero}, 32'd1);

    // Backpressure with a competing in_valid that must be ignored
    issue(11'h0A0, 1'b0);
    expect_result("f1p25", 24'd608, 1'b0);
    in_valid = 1'b1;
    in_log   = 11'h060;
    in_zero  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_y", {8'd0, out_y}, 32'd608);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_y_held_idle", {8'd0, out_y}, 32'd608);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accept", {31'd0, in_ready}, 32'd0);
    expect_result("bp_next", 24'd430, 1'b0);
    take();

    // Reset during CALC step 4 of a 7.5 transaction
    issue(11'h3C0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_y", {8'd0, out_y}, 32'd0);
    check("midrst_out_zero", {31'd0, out_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_valid", {31'd0, out_valid}, 32'd0);
    issue(11'h000, 1'b0);
    expect_result("postrst_one", 24'h000100, 1'b0);
    take();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp2_seq.md
# exp2_seq

Sequential antilog (2^x) unit placed directly downstream of the log2 stage. It accepts an 11-bit unsigned fixed-point base-2 logarithm, Q4.7, over a valid/ready handshake. It rebuilds 2^x by multiplying a Q1.16 accumulator by per-fraction-bit constants, one bit per cycle, then applies the integer part as a left shift. The Q16.8 result lets the pipeline close log-domain arithmetic, such as multiply-by-add or root-by-shift, back into the linear domain.

## Interface
- No parameters. Widths and constants are fixed by the upstream Q4.7 log format.
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream presents a log value.
- in_ready  output  1  block can accept; high only in IDLE.
- in_log  input  11  log value, Q4.7: [10:7] integer part I (0..15), [6:0] fraction F.
- in_zero  input  1  upstream operand was 0 (log undefined); sampled with in_log.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_y  output  24  2^x, unsigned Q16.8.
- out_zero  output  1  result corresponds to a zero operand; out_y = 0.

## Operation
- States: IDLE, CALC, FINAL, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid: latch I, F and in_zero.
  - Set acc = 65536 (1.0 in Q1.16, 17 bits) and step counter k = 0.
  - Go to CALC.
- **CALC** (7 cycles, k = 0..6), processes fraction bit F[6-k], MSB first:
  - If F[6-k] = 1: acc = floor(acc * C[k] / 65536). Otherwise acc is unchanged.
  - Multiplier is 17x17 bits; the product is truncated, never rounded.
  - C[0..6] = 92682, 77937, 71468, 68438, 66971, 66250, 65892. These are round(2^(2^-(k+1)) * 65536).
  - acc stays below 2^17 for every input; no overflow handling is required.
  - After k = 6, go to FINAL.
- **FINAL** (1 cycle):
  - out_y = (acc << I) >> 8. The intermediate is 32 bits; keep the low 24 bits, which always fit.
  - If the latched zero flag is set: out_y = 0 and out_zero = 1. The CALC result is discarded.
  - Go to DONE.
- **DONE**
  - out_valid = 1. out_y and out_zero are held stable.
  - On out_ready: go to IDLE.
- Single transaction in flight only; no input/output overlap.
- Inputs are ignored outside IDLE.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_y = 0, out_zero = 0, state IDLE, acc = 65536, k = 0.
- Handshake rules:
  - Transfers occur on the rising edge where valid && ready.
  - out_valid never drops until out_ready is seen.
- Latency:
  - Acceptance at edge n. CALC covers edges n+1..n+7. FINAL is at edge n+8.
  - out_valid is high from edge n+9 onward.
  - Result taken at edge m (out_valid && out_ready): in_ready is high from edge m onward, so the next accept is at edge m+1 at the earliest.
  - Minimum issue interval is 10 cycles.
- in_zero does not shorten latency; the pipeline timing is uniform.
- out_y and out_zero keep the last result while in IDLE until the next FINAL overwrites them.
- Asynchronous rst at any state, including mid-CALC:
  - Immediately forces the reset values.
  - The in-flight transaction is dropped; no partial result appears.
- Simultaneous out_ready with reset: reset wins.

## Test plan
- Reset, then in_log = 0 (I=0, F=0): out_valid high 9 cycles after accept, out_y = 0x000100 (1.0), out_zero = 0.
- Integer only: in_log = 3<<7 -> out_y = 2048 (8.0). in_log = 15<<7 -> out_y = 0x800000 (32768.0).
- Fraction bits:
  - in_log = 0x040 (0.5) -> out_y = 362.
  - in_log = 0x0A0 (1.25) -> out_y = 608.
  - in_log = 0x3C0 (7.5) -> out_y = 46341 (0x00B505).
- Zero operand: in_zero = 1 with in_log = 0x3C0 -> out_y = 0, out_zero = 1, same 9-cycle latency.
- Backpressure: hold out_ready low 20 cycles after out_valid.
  - out_y stable, in_ready low, a new in_valid is ignored.
  - Then assert out_ready for one cycle: in_ready rises and the next transaction is accepted the following edge.
- Assert rst at CALC step 4 of an in_log = 0x3C0 transaction:
  - Outputs immediately return to reset values.
  - A subsequent in_log = 0 produces exactly 0x000100.
